// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   alu_op_e    : 4-bit opcode encoding; all 16 codes are defined
//   alu_state_e : control FSM states
//   FLAG_*      : bit positions inside the 4-bit flags bus {dz, ovf, carry, zero}
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_SHL1 = 4'h4,
    OP_SHR1 = 4'h5,
    OP_ROL1 = 4'h6,
    OP_ROR1 = 4'h7,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_XOR  = 4'hA,
    OP_NOR  = 4'hB,
    OP_NAND = 4'hC,
    OP_XNOR = 4'hD,
    OP_GT   = 4'hE,
    OP_EQ   = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_DZ    = 3;
  localparam int NUM_FLAGS  = 4;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative multiply / divide engine, one bit per clock, WIDTH iterations.
//   clk, rst_n : clock, async active-low reset (clears the iteration counter)
//   start      : load operands and begin; sampled every cycle
//   op         : OP_MUL -> unsigned shift-add product
//                OP_DIV -> unsigned restoring division, result {remainder, quotient}
//   opa, opb   : operands (opb must be nonzero for OP_DIV)
//   done       : high during the cycle in which the final iteration is clocked
//   result     : value the datapath takes at the next edge; valid when done=1
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  alu_op_e            op,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  // hi: partial product / remainder, lo: multiplier / dividend-quotient,
  // m: multiplicand / divisor
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    m_d   = m_q;
    div_d = div_q;
    cnt_d = cnt_q;
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    r_sh  = {hi_q, lo_q[WIDTH-1]};
    diff  = r_sh - {1'b0, m_q};

    if (start) begin
      div_d = (op == OP_DIV);
      cnt_d = CW'(WIDTH);
      hi_d  = '0;
      if (op == OP_DIV) begin
        m_d  = opb;
        lo_d = opa;
      end else begin
        m_d  = opa;
        lo_d = opb;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (div_q) begin
        // trial subtract; keep the shifted remainder when the divisor does not fit
        if (r_sh >= {1'b0, m_q}) begin
          hi_d = diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = r_sh[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        // add-then-shift-right; the carry of the add becomes the new top bit
        hi_d = sum[WIDTH:1];
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  assign done   = (cnt_q == CW'(1));
  assign result = {hi_d, lo_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      m_q   <= m_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake on both sides.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : request handshake; a, b, alu_sel captured on accept
//   a, b                : WIDTH-bit operands
//   alu_sel             : opcode (alu_op_e)
//   out_valid/out_ready : result handshake; result held while out_ready=0
//   alu_out             : 2*WIDTH-bit result
//   flags               : {dz, ovf, carry, zero}
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// CALC  | MUL/DIV iterating in seq_muldiv for WIDTH cycles
// DONE  | result presented, waiting for out_ready
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         alu_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] alu_out,
  output logic [3:0]         flags
);

  alu_state_e         state_q, state_d;
  alu_op_e            op_q, op_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] alu_out_q, alu_out_d;
  logic [3:0]         flags_q, flags_d;

  alu_op_e            sel;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [WIDTH-1:0]   sc_lo;
  logic [WIDTH-1:0]   sc_hi;
  logic               sc_carry;
  logic               sc_ovf;
  logic               sc_dz;
  logic [2*WIDTH-1:0] sc_out;
  logic [3:0]         sc_flags;
  logic               is_iter;

  logic               md_start;
  logic               md_done;
  logic [2*WIDTH-1:0] md_result;

  assign sel = alu_op_e'(alu_sel);

  // single-cycle datapath, evaluated on the live inputs at the accept edge
  always_comb begin
    sum_w    = {1'b0, a} + {1'b0, b};
    diff_w   = {1'b0, a} - {1'b0, b};
    sc_lo    = '0;
    sc_hi    = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_dz    = 1'b0;
    case (sel)
      OP_ADD: begin
        sc_lo    = sum_w[WIDTH-1:0];
        sc_carry = sum_w[WIDTH];
        sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_lo    = diff_w[WIDTH-1:0];
        sc_carry = diff_w[WIDTH];
        sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL: ;
      OP_DIV: begin
        // only reaches the output when b == 0
        sc_hi = a;
        sc_lo = '1;
        sc_dz = 1'b1;
      end
      OP_SHL1: begin
        sc_lo    = {a[WIDTH-2:0], 1'b0};
        sc_carry = a[WIDTH-1];
      end
      OP_SHR1: begin
        sc_lo    = {1'b0, a[WIDTH-1:1]};
        sc_carry = a[0];
      end
      OP_ROL1: begin
        sc_lo    = {a[WIDTH-2:0], a[WIDTH-1]};
        sc_carry = a[WIDTH-1];
      end
      OP_ROR1: begin
        sc_lo    = {a[0], a[WIDTH-1:1]};
        sc_carry = a[0];
      end
      OP_AND:  sc_lo = a & b;
      OP_OR:   sc_lo = a | b;
      OP_XOR:  sc_lo = a ^ b;
      OP_NOR:  sc_lo = ~(a | b);
      OP_NAND: sc_lo = ~(a & b);
      OP_XNOR: sc_lo = ~(a ^ b);
      OP_GT:   sc_lo = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_EQ:   sc_lo = {{(WIDTH-1){1'b0}}, (a == b)};
    endcase
    sc_out               = {sc_hi, sc_lo};
    sc_flags             = '0;
    sc_flags[FLAG_ZERO]  = (sc_out == '0);
    sc_flags[FLAG_CARRY] = sc_carry;
    sc_flags[FLAG_OVF]   = sc_ovf;
    sc_flags[FLAG_DZ]    = sc_dz;
  end

  assign is_iter = (sel == OP_MUL) || ((sel == OP_DIV) && (b != '0));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    out_valid_d = out_valid_q;
    alu_out_d   = alu_out_q;
    flags_d     = flags_q;
    md_start    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          op_d = sel;
          if (is_iter) begin
            md_start = 1'b1;
            state_d  = ST_CALC;
          end else begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            alu_out_d   = sc_out;
            flags_d     = sc_flags;
          end
        end
      end
      ST_CALC: begin
        if (md_done) begin
          state_d            = ST_DONE;
          out_valid_d        = 1'b1;
          alu_out_d          = md_result;
          flags_d            = '0;
          flags_d[FLAG_ZERO] = (md_result == '0);
          flags_d[FLAG_OVF]  = (op_q == OP_MUL) && (md_result[2*WIDTH-1:WIDTH] != '0);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      flags_q     <= flags_d;
    end
  end

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .op     (sel),
    .opa    (a),
    .opb    (b),
    .done   (md_done),
    .result (md_result)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [3:0]  alu_sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] alu_out;
  logic [3:0]  flags;

  int n_chk  = 0;
  int n_fail = 0;

  seq_alu #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_sel   (alu_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] out;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // drive a request at a negedge; returns just after the accept edge with
  // operands scrambled so late changes would show up in the result
  task automatic issue(input logic [3:0] op, input logic [7:0] ia, input logic [7:0] ib);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    alu_sel  = op;
    a        = ia;
    b        = ib;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = ~ia;
    b        = ib ^ 8'h5A;
    alu_sel  = op ^ 4'h3;
  endtask

  task automatic wait_valid(output int lat);
    bit stop;
    lat  = 0;
    stop = 0;
    while (!stop) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        stop = 1;
      end else begin
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        if (lat >= 40) begin
          n_chk++;
          n_fail++;
          $display("FAIL out_valid_timeout: got no out_valid after %0d cycles, required within 40", lat);
          stop = 1;
        end
      end
    end
  endtask

  // called at a negedge with out_valid high
  task automatic ack_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("ack_in_ready", 32'(in_ready), 32'd1);
    chk("ack_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    logic [15:0] held;

    //           op     a      b      out       flags    lat
    vecs.push_back('{4'h0, 8'd200, 8'd100, 16'h002C, 4'b0010, 1}); // ADD carry
    vecs.push_back('{4'h1, 8'd5,   8'd10,  16'h00FB, 4'b0010, 1}); // SUB borrow
    vecs.push_back('{4'h1, 8'h80,  8'h01,  16'h007F, 4'b0100, 1}); // SUB ovf
    vecs.push_back('{4'h0, 8'h7F,  8'h01,  16'h0080, 4'b0100, 1}); // ADD ovf
    vecs.push_back('{4'h0, 8'hFF,  8'h01,  16'h0000, 4'b0011, 1}); // ADD wrap to zero
    vecs.push_back('{4'h4, 8'h81,  8'h00,  16'h0002, 4'b0010, 1}); // SHL1
    vecs.push_back('{4'h5, 8'h81,  8'h00,  16'h0040, 4'b0010, 1}); // SHR1
    vecs.push_back('{4'h6, 8'h81,  8'h00,  16'h0003, 4'b0010, 1}); // ROL1
    vecs.push_back('{4'h7, 8'h81,  8'h00,  16'h00C0, 4'b0010, 1}); // ROR1
    vecs.push_back('{4'h4, 8'h00,  8'h00,  16'h0000, 4'b0001, 1}); // SHL1 zero
    vecs.push_back('{4'h8, 8'hF0,  8'h3C,  16'h0030, 4'b0000, 1}); // AND
    vecs.push_back('{4'h9, 8'hF0,  8'h3C,  16'h00FC, 4'b0000, 1}); // OR
    vecs.push_back('{4'hA, 8'hF0,  8'h3C,  16'h00CC, 4'b0000, 1}); // XOR
    vecs.push_back('{4'hB, 8'hF0,  8'h3C,  16'h0003, 4'b0000, 1}); // NOR
    vecs.push_back('{4'hC, 8'hF0,  8'h3C,  16'h00CF, 4'b0000, 1}); // NAND
    vecs.push_back('{4'hD, 8'hF0,  8'h3C,  16'h0033, 4'b0000, 1}); // XNOR
    vecs.push_back('{4'hE, 8'd200, 8'd100, 16'h0001, 4'b0000, 1}); // GT unsigned
    vecs.push_back('{4'hE, 8'd3,   8'd5,   16'h0000, 4'b0001, 1}); // GT false
    vecs.push_back('{4'hF, 8'd3,   8'd3,   16'h0001, 4'b0000, 1}); // EQ
    vecs.push_back('{4'hF, 8'd3,   8'd4,   16'h0000, 4'b0001, 1}); // EQ false
    vecs.push_back('{4'h3, 8'd9,   8'd0,   16'h09FF, 4'b1000, 1}); // DIV by zero
    vecs.push_back('{4'h2, 8'd255, 8'd255, 16'hFE01, 4'b0100, 9}); // MUL max
    vecs.push_back('{4'h2, 8'd15,  8'd15,  16'h00E1, 4'b0000, 9}); // MUL small
    vecs.push_back('{4'h2, 8'd16,  8'd16,  16'h0100, 4'b0100, 9}); // MUL upper half
    vecs.push_back('{4'h2, 8'd0,   8'd5,   16'h0000, 4'b0001, 9}); // MUL zero
    vecs.push_back('{4'h3, 8'd100, 8'd7,   16'h020E, 4'b0000, 9}); // DIV
    vecs.push_back('{4'h3, 8'd7,   8'd100, 16'h0700, 4'b0000, 9}); // DIV a<b
    vecs.push_back('{4'h3, 8'd255, 8'd1,   16'h00FF, 4'b0000, 9}); // DIV by one

    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_out", 32'(alu_out), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].op, vecs[i].va, vecs[i].vb);
      wait_valid(lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_out", i), 32'(alu_out), 32'(vecs[i].out));
      chk($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].fl));
      ack_result();
    end

    // hold in DONE with out_ready low while the request side keeps pushing
    issue(4'h0, 8'h10, 8'h22);
    wait_valid(lat);
    chk("hold_lat", 32'(lat), 32'd1);
    held = 16'h0032;
    chk("hold_first", 32'(alu_out), 32'(held));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a        = 8'($urandom);
      b        = 8'($urandom);
      alu_sel  = 4'($urandom);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_out", k), 32'(alu_out), 32'(held));
      chk($sformatf("hold%0d_flags", k), 32'(flags), 32'd0);
      chk($sformatf("hold%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d_ready", k), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    ack_result();

    // reset in the middle of a DIV: outputs clear at once, nothing delivered
    issue(4'h3, 8'd100, 8'd7);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_alu_out", 32'(alu_out), 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("abort_quiet%0d", k), 32'(out_valid), 32'd0);
    end
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    issue(4'hF, 8'd3, 8'd3);
    wait_valid(lat);
    chk("post_rst_lat", 32'(lat), 32'd1);
    chk("post_rst_out", 32'(alu_out), 32'h0001);
    chk("post_rst_flags", 32'(flags), 32'd0);
    ack_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a  input  WIDTH  operand A, unsigned; signed only for the overflow flag.
REQ-007 b  input  WIDTH  operand B.
REQ-008 alu_sel  input  4  opcode.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 alu_out  output  2*WIDTH  result.
REQ-012 flags  output  4  {dz, ovf, carry, zero}.

Function
REQ-013 Opcodes: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 SHL1, 0101 SHR1, 0110 ROL1, 0111 ROR1, 1000 AND, 1001 OR, 1010 XOR, 1011 NOR, 1100 NAND, 1101 XNOR, 1110 GT (A>B unsigned), 1111 EQ; no undefined opcode exists.
REQ-014 Request accepted on a rising edge with in_valid=1 and in_ready=1; a, b, alu_sel captured at that edge; later operand changes have no effect.
REQ-015 FSM states IDLE, CALC, DONE; in_ready=1 only in IDLE.
REQ-016 IDLE -> DONE on acceptance of any opcode except MUL/DIV (out_valid high one cycle after the accept edge).
REQ-017 IDLE -> CALC on acceptance of MUL or DIV with b!=0; CALC lasts exactly WIDTH cycles (one bit per cycle), then DONE; out_valid high WIDTH+1 cycles after the accept edge.
REQ-018 DIV with b=0: IDLE -> DONE directly; alu_out = {a, all-ones quotient}; dz=1.
REQ-019 DONE -> IDLE on an edge with out_ready=1; while out_ready=0, alu_out and flags are held stable.
REQ-020 No new request is accepted in the DONE cycle itself; the next accept is possible the cycle after return to IDLE.
REQ-021 Non-MUL/DIV results occupy alu_out[WIDTH-1:0]; the upper half is zero.
REQ-022 MUL: alu_out = full 2*WIDTH unsigned product.
REQ-023 DIV: alu_out = {remainder, quotient}, unsigned, restoring algorithm.
REQ-024 GT/EQ: alu_out = 1 or 0.
REQ-025 carry: ADD carry-out; SUB borrow (a<b); SHL1/ROL1 = a[WIDTH-1]; SHR1/ROR1 = a[0]; all other opcodes 0.
REQ-026 ovf: signed overflow for ADD/SUB; for MUL, set if the upper half is nonzero; all other opcodes 0.
REQ-027 zero: alu_out == 0 over all 2*WIDTH bits.
REQ-028 dz: set only for DIV with b=0.

Reset
REQ-029 rst_n low forces, asynchronously, state=IDLE, in_ready=1 (after release), out_valid=0, alu_out=0, flags=0, iteration counter=0.
REQ-030 Reset asserted during CALC or DONE aborts the operation; no result is ever delivered for it.

Structure
REQ-031 Package alu_pkg holds the opcode enum (4-bit), the FSM state enum, and the flag bit-index constants.
REQ-032 One sub-module, seq_muldiv, implements the shared shift-add/shift-subtract engine (start, op, done; WIDTH iterations); the top holds the FSM, single-cycle ops, and output registers.

Verification (WIDTH=8)
REQ-033 ADD a=200 b=100 -> alu_out=0x002C, carry=1, ovf=0, out_valid 1 cycle after accept.
REQ-034 SUB a=5 b=10 -> alu_out=0x00FB, carry=1; SUB a=0x80 b=1 -> 0x007F, ovf=1.
REQ-035 MUL a=255 b=255 -> alu_out=0xFE01, ovf=1, out_valid exactly 9 cycles after accept; in_ready=0 throughout.
REQ-036 DIV a=100 b=7 -> alu_out=0x020E after 9 cycles; DIV a=9 b=0 -> alu_out=0x09FF, dz=1 after 1 cycle.
REQ-037 Hold out_ready=0 for 5 cycles in DONE while toggling a/b -> alu_out stable, no new accept; out_ready=1 -> IDLE next edge.
REQ-038 Assert rst_n=0 at cycle 4 of a DIV -> outputs zero immediately; after release, a fresh EQ a=3 b=3 returns 0x0001 with no stale result.
